// File: rtl/imem_program_loader.sv
// Packs streamed instruction fields into 16-bit words and writes them to imem from address 0.
// Optional macro IMEM_HALT_FILL_EN: after HALT, pad the rest of memory with HALT words.
module imem_program_loader #(
  parameter int ADDR_W   = 8,
  parameter int HOLD_CPU = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [3:0]        OP_HALT   = 4'hF;
  localparam logic [15:0]       HALT_WORD = {OP_HALT, 12'h000};
  localparam logic [ADDR_W-1:0] LAST      = '1;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2_imm;
  } instr_t;

`ifdef IMEM_HALT_FILL_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t state;
  instr_t beat;
  logic   halt_pend;

  assign beat      = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2_imm: in_rs2_imm};
  // The pending word's own opcode tells us whether the session ends after this write.
  assign halt_pend = (imem_wdata[15:12] == OP_HALT);
  assign cpu_hold  = (HOLD_CPU != 0) ? busy : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LOAD;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            imem_addr  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (imem_we) begin
            // Write strobe is on the bus this cycle; decide what follows it.
            imem_we <= 1'b0;
            if (halt_pend) begin
`ifdef IMEM_HALT_FILL_EN
              if (imem_addr != LAST) begin
                state      <= S_FILL;
                imem_we    <= 1'b1;
                imem_addr  <= imem_addr + 1'b1;
                imem_wdata <= HALT_WORD;
              end else
`endif
              begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else if (imem_addr == LAST) begin
              state <= S_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              imem_addr <= imem_addr + 1'b1;
              in_ready  <= 1'b1;
            end
          end else if (in_valid && in_ready) begin
            imem_we    <= 1'b1;
            in_ready   <= 1'b0;
            imem_wdata <= (beat.opcode == OP_HALT) ? HALT_WORD : beat;
            word_count <= word_count + 1'b1;
          end
        end
`ifdef IMEM_HALT_FILL_EN
        S_FILL: begin
          // One pad word per cycle; strobe stays high until the top address is written.
          if (imem_addr == LAST) begin
            state   <= S_DONE;
            imem_we <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            imem_addr <= imem_addr + 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench: an 8-bit-address loader and a 2-bit-address loader share clk/rst.
module tb_imem_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        st0 = 0, v0 = 0, rdy0, we0, busy0, done0, err0, hold0;
  logic [15:0] b0 = 0, wd0;
  logic [7:0]  addr0;
  logic [8:0]  wc0;
  logic        st1 = 0, v1 = 0, rdy1, we1, busy1, done1, err1, hold1;
  logic [15:0] b1 = 0, wd1;
  logic [1:0]  addr1;
  logic [2:0]  wc1;

  imem_program_loader #(.ADDR_W(8), .HOLD_CPU(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(st0), .in_valid(v0), .in_ready(rdy0),
    .in_opcode(b0[15:12]), .in_rd(b0[11:8]), .in_rs1(b0[7:4]), .in_rs2_imm(b0[3:0]),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0), .word_count(wc0),
    .busy(busy0), .done(done0), .error(err0), .cpu_hold(hold0));

  imem_program_loader #(.ADDR_W(2), .HOLD_CPU(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .in_valid(v1), .in_ready(rdy1),
    .in_opcode(b1[15:12]), .in_rd(b1[11:8]), .in_rs1(b1[7:4]), .in_rs2_imm(b1[3:0]),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .word_count(wc1),
    .busy(busy1), .done(done1), .error(err1), .cpu_hold(hold1));

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  ma[2];
  int  depth[2] = '{256, 4};
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Each strobe cycle must match the oldest expected write, including its cycle.
  always @(negedge clk) begin : mon0
    wr_t e;
    if (we0) begin
      if (q0.size() == 0) chk("wr0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("wr0_addr", addr0, e.addr);
        chk("wr0_data", wd0, e.data);
        chk("wr0_cyc", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    wr_t e;
    if (we1) begin
      if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("wr1_addr", addr1, e.addr);
        chk("wr1_data", wd1, e.data);
        chk("wr1_cyc", cyc, e.cyc);
      end
    end
  end

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic get_end(input int d);
    return (d == 0) ? (done0 | err0) : (done1 | err1);
  endfunction

  task automatic drive(input int d, input logic v, input logic [15:0] w);
    if (d == 0) begin v0 = v; b0 = w; end
    else begin v1 = v; b1 = w; end
  endtask

  task automatic push(input int d, input int a, input logic [15:0] x, input int c);
    wr_t e;
    e.addr = a; e.data = x; e.cyc = c;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pulse_start(input int d, input bit reset_model);
    @(negedge clk);
    if (d == 0) st0 = 1'b1; else st1 = 1'b1;
    @(negedge clk);
    if (d == 0) st0 = 1'b0; else st1 = 1'b0;
    if (reset_model) ma[d] = 0;
  endtask

  task automatic send(input int d, input logic [15:0] w);
    int n = 0;
    logic halt;
    @(negedge clk);
    drive(d, 1'b1, w);
    while (!get_rdy(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("rdy_timeout", 0, 1);
      drive(d, 1'b0, w);
      return;
    end
    halt = (w[15:12] == 4'hF);
    push(d, ma[d], halt ? 16'hF000 : w, cyc + 1);
`ifdef IMEM_HALT_FILL_EN
    if (halt)
      for (int a = ma[d] + 1; a < depth[d]; a++)
        push(d, a, 16'hF000, cyc + 1 + (a - ma[d]));
`endif
    ma[d]++;
    @(posedge clk);
    #1 drive(d, 1'b0, w);
  endtask

  task automatic wait_end(input int d);
    int n = 0;
    @(negedge clk);
    while (!get_end(d) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("end_timeout", 0, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we0", we0, 0);   chk("rst_rdy0", rdy0, 0); chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0); chk("rst_err0", err0, 0); chk("rst_hold0", hold0, 0);
    chk("rst_addr0", addr0, 0); chk("rst_wc0", wc0, 0); chk("rst_rdy1", rdy1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy0", rdy0, 0); chk("post_rst_busy0", busy0, 0); chk("post_rst_wd0", wd0, 0);

    // in_valid while idle does nothing
    @(negedge clk);
    drive(1, 1'b1, 16'h4321);
    repeat (3) @(negedge clk);
    drive(1, 1'b0, 16'h4321);
    chk("idle_wc1", wc1, 0); chk("idle_rdy1", rdy1, 0);

    pulse_start(0, 1'b1);
    chk("start_rdy0", rdy0, 1); chk("start_busy0", busy0, 1); chk("start_hold0", hold0, 1);

    // Basic program ending in HALT
    send(0, 16'h0123);
    send(0, 16'h8405);
    send(0, 16'hF777);
    wait_end(0);
    chk("prog_done0", done0, 1); chk("prog_err0", err0, 0); chk("prog_wc0", wc0, 3);
    chk("prog_busy0", busy0, 0); chk("prog_hold0", hold0, 0); chk("prog_rdy0", rdy0, 0);
    repeat (2) @(negedge clk);
    chk("done_sticky0", done0, 1);

    // Restart clears flags; start mid-LOAD is ignored
    pulse_start(0, 1'b1);
    chk("restart_done0", done0, 0); chk("restart_wc0", wc0, 0);
    send(0, 16'h5A5A);
    pulse_start(0, 1'b0);
    send(0, 16'h6B6B);
    @(negedge clk);
    chk("midstart_wc0", wc0, 2); chk("midstart_busy0", busy0, 1);

    // Reset while a write is pending drops it
    @(negedge clk);
    drive(0, 1'b1, 16'h2111);
    chk("pend_rdy0", rdy0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 1'b0, 16'h2111);
    #1;
    chk("pend_we0", we0, 0); chk("pend_addr0", addr0, 0); chk("pend_wc0", wc0, 0);
    chk("pend_busy0", busy0, 0); chk("pend_rdy_after0", rdy0, 0); chk("pend_wd0", wd0, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(0, 1'b1);
    send(0, 16'h3000);
    @(negedge clk);
    chk("fresh_wc0", wc0, 1);

    // Small memory: fill without HALT -> error
    pulse_start(1, 1'b1);
    for (int i = 0; i < 4; i++) send(1, 16'h1111);
    wait_end(1);
    chk("full_err1", err1, 1); chk("full_done1", done1, 0);
    chk("full_wc1", wc1, 4); chk("full_busy1", busy1, 0);
    @(negedge clk);
    drive(1, 1'b1, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_rdy1", rdy1, 0);
    end
    drive(1, 1'b0, 16'h1111);

    // Early HALT on small memory
    pulse_start(1, 1'b1);
    chk("restart_err1", err1, 0);
    send(1, 16'h2123);
    send(1, 16'hF555);
    wait_end(1);
    chk("halt1_done", done1, 1); chk("halt1_err", err1, 0); chk("halt1_wc", wc1, 2);

    // HALT in the last slot ends DONE, not ERR
    pulse_start(1, 1'b1);
    send(1, 16'h1111);
    send(1, 16'h2222);
    send(1, 16'h3333);
    send(1, 16'hFABC);
    wait_end(1);
    chk("lasthalt_done1", done1, 1); chk("lasthalt_err1", err1, 0); chk("lasthalt_wc1", wc1, 4);

    repeat (5) @(negedge clk);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
